// File: rtl/blk_mem_gen_dp_param.sv
// blk_mem_gen_dp_param: parametrised true-dual-port block RAM model.
// One clock, byte-lane writes, per-port write mode, optional output register.
module blk_mem_gen_dp_param #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 9,
  parameter int NUM_LANES = 1,
  parameter int WMODE_A = 0,
  parameter int WMODE_B = 0,
  parameter int OUT_REG = 0,
  parameter logic [DATA_W-1:0] RST_VAL = '0
) (
  input  logic                 clka,
  input  logic                 rsta,
  input  logic                 ena,
  input  logic [NUM_LANES-1:0] wea,
  input  logic [ADDR_W-1:0]    addra,
  input  logic [DATA_W-1:0]    dina,
  input  logic                 regcea,
  output logic [DATA_W-1:0]    douta,
  input  logic                 enb,
  input  logic [NUM_LANES-1:0] web,
  input  logic [ADDR_W-1:0]    addrb,
  input  logic [DATA_W-1:0]    dinb,
  input  logic                 regceb,
  output logic [DATA_W-1:0]    doutb
);

  localparam int LANE_W = DATA_W / NUM_LANES;
  localparam int DEPTH = 2 ** ADDR_W;

  if (LANE_W * NUM_LANES != DATA_W) begin : g_bad_lanes
    $error("NUM_LANES must divide DATA_W exactly");
  end

  logic [DATA_W-1:0] mem [DEPTH] = '{default: '0};

  logic [DATA_W-1:0] lat_a, lat_b;
  logic [DATA_W-1:0] old_a, old_b;
  logic              xa, xb;
  logic              wr_a, wr_b;

  function automatic logic [DATA_W-1:0] merge(
    input logic [DATA_W-1:0]    old,
    input logic [DATA_W-1:0]    din,
    input logic [NUM_LANES-1:0] we
  );
    merge = old;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (we[i]) merge[i*LANE_W +: LANE_W] = din[i*LANE_W +: LANE_W];
    end
  endfunction

  assign old_a = mem[addra];
  assign old_b = mem[addrb];
  assign xa = $isunknown(addra);
  assign xb = $isunknown(addrb);
  assign wr_a = |wea;
  assign wr_b = |web;

  always_ff @(posedge clka) begin
    if (rsta) begin
      lat_a <= RST_VAL;
      lat_b <= RST_VAL;
    end else begin
      if (ena) begin
        if (xa) lat_a <= 'x;
        else if (!wr_a) lat_a <= old_a;
        else if (WMODE_A == 0) lat_a <= merge(old_a, dina, wea);
        else if (WMODE_A == 1) lat_a <= old_a;
      end
      if (enb) begin
        if (xb) lat_b <= 'x;
        else if (!wr_b) lat_b <= old_b;
        else if (WMODE_B == 0) lat_b <= merge(old_b, dinb, web);
        else if (WMODE_B == 1) lat_b <= old_b;
      end
      // port A is written last so it owns overlapping lanes on a collision
      for (int i = 0; i < NUM_LANES; i++) begin
        if (enb && !xb && web[i])
          mem[addrb][i*LANE_W +: LANE_W] <= dinb[i*LANE_W +: LANE_W];
      end
      for (int i = 0; i < NUM_LANES; i++) begin
        if (ena && !xa && wea[i])
          mem[addra][i*LANE_W +: LANE_W] <= dina[i*LANE_W +: LANE_W];
      end
    end
  end

  if (OUT_REG != 0) begin : g_oreg
    logic [DATA_W-1:0] reg_a, reg_b;
    always_ff @(posedge clka) begin
      if (rsta) begin
        reg_a <= RST_VAL;
        reg_b <= RST_VAL;
      end else begin
        if (regcea) reg_a <= lat_a;
        if (regceb) reg_b <= lat_b;
      end
    end
    assign douta = reg_a;
    assign doutb = reg_b;
  end else begin : g_noreg
    logic unused_regce;
    assign unused_regce = regcea ^ regceb;
    assign douta = lat_a;
    assign doutb = lat_b;
  end

endmodule

// File: tb/tb_blk_mem_gen_dp_param.sv
// tb_blk_mem_gen_dp_param: scoreboard bench for the dual-port RAM model.
// Four instances cover write modes, output register and byte lanes.
module tb_blk_mem_gen_dp_param;

  logic clk = 0;
  always #5 clk = ~clk;

  logic        rsta;
  logic        ena, enb, regcea, regceb;
  logic [0:0]  wea, web;
  logic [11:0] addra, addrb;
  logic [8:0]  dina, dinb;
  logic [8:0]  a0, b0, a1, b1, a2, b2;

  logic        wena, wenb;
  logic [1:0]  wwea, wweb;
  logic [11:0] waddra, waddrb;
  logic [15:0] wdina, wdinb;
  logic [15:0] a3, b3;

  blk_mem_gen_dp_param #(.WMODE_A(0), .OUT_REG(0), .RST_VAL(9'h1A5)) u0 (
    .clka(clk), .rsta(rsta), .ena(ena), .wea(wea), .addra(addra),
    .dina(dina), .regcea(regcea), .douta(a0), .enb(enb), .web(web),
    .addrb(addrb), .dinb(dinb), .regceb(regceb), .doutb(b0));

  blk_mem_gen_dp_param #(.WMODE_A(1), .OUT_REG(1), .RST_VAL(9'h1A5)) u1 (
    .clka(clk), .rsta(rsta), .ena(ena), .wea(wea), .addra(addra),
    .dina(dina), .regcea(regcea), .douta(a1), .enb(enb), .web(web),
    .addrb(addrb), .dinb(dinb), .regceb(regceb), .doutb(b1));

  blk_mem_gen_dp_param #(.WMODE_A(2), .OUT_REG(0), .RST_VAL(9'h1A5)) u2 (
    .clka(clk), .rsta(rsta), .ena(ena), .wea(wea), .addra(addra),
    .dina(dina), .regcea(regcea), .douta(a2), .enb(enb), .web(web),
    .addrb(addrb), .dinb(dinb), .regceb(regceb), .doutb(b2));

  blk_mem_gen_dp_param #(.DATA_W(16), .NUM_LANES(2)) u3 (
    .clka(clk), .rsta(rsta), .ena(wena), .wea(wwea), .addra(waddra),
    .dina(wdina), .regcea(1'b1), .douta(a3), .enb(wenb), .web(wweb),
    .addrb(waddrb), .dinb(wdinb), .regceb(1'b1), .doutb(b3));

  typedef struct packed {
    int          due;
    int          sel;
    logic [15:0] val;
  } exp_t;

  exp_t  sb[$];
  string tq[$];
  exp_t  e;
  string t;
  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  logic [15:0] hist [1024][8];

  function automatic logic [15:0] outv(input int s);
    case (s)
      0: outv = 16'(a0);
      1: outv = 16'(b0);
      2: outv = 16'(a1);
      3: outv = 16'(b1);
      4: outv = 16'(a2);
      5: outv = 16'(b2);
      6: outv = a3;
      default: outv = b3;
    endcase
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (cyc < 1024)
      for (int s = 0; s < 8; s++) hist[cyc][s] = outv(s);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int due, input int sel,
                      input logic [15:0] val, input string tag);
    exp_t x;
    x.due = due;
    x.sel = sel;
    x.val = val;
    sb.push_back(x);
    tq.push_back(tag);
  endtask

  task automatic test_reset;
    int c0;
    c0 = cyc;
    rsta = 1;
    ena = 1; wea = 1; addra = 12'd20; dina = 9'h077;
    enb = 1; web = 1; addrb = 12'd21; dinb = 9'h066;
    wena = 1; wwea = 2'b11; waddra = 12'd20; wdina = 16'hBEEF;
    wenb = 1; wweb = 2'b11; waddrb = 12'd21; wdinb = 16'hCAFE;
    for (int s = 0; s < 6; s++) push(c0 + 2, s, 16'h1A5, "rst_out");
    push(c0 + 2, 6, 16'h0, "rst_out_lanes_a");
    push(c0 + 2, 7, 16'h0, "rst_out_lanes_b");
    tick;
    tick;
    c0 = cyc;
    rsta = 0; wea = 0; web = 0; wwea = 2'b00; wweb = 2'b00;
    push(c0 + 1, 0, 16'h0, "rst_nowr_a");
    push(c0 + 1, 1, 16'h0, "rst_nowr_b");
    push(c0 + 1, 4, 16'h0, "rst_nowr_nc_a");
    push(c0 + 1, 5, 16'h0, "rst_nowr_nc_b");
    push(c0 + 1, 2, 16'h1A5, "oreg_a_pre");
    push(c0 + 2, 2, 16'h0, "oreg_a_lat2");
    push(c0 + 2, 3, 16'h0, "oreg_b_lat2");
    push(c0 + 1, 6, 16'h0, "rst_nowr_lanes");
    tick;
    ena = 0; enb = 0; wena = 0; wenb = 0;
    tick;
    @(negedge clk); #1;
    while (sb.size() > 0) begin
      e = sb.pop_front(); t = tq.pop_front(); checks++;
      if (e.due > cyc) begin
        errors++; $display("FAIL %s no output by cycle %0d", t, cyc);
      end else if (hist[e.due][e.sel] !== e.val) begin
        errors++; $display("FAIL %s got %h want %h", t, hist[e.due][e.sel], e.val);
      end
    end
  endtask

  task automatic test_latency;
    int c0;
    c0 = cyc;
    ena = 1; wea = 1; addra = 12'h3FF; dina = 9'h0AB;
    enb = 0; regceb = 1;
    tick;
    ena = 0; wea = 0;
    enb = 1; web = 0; addrb = 12'h3FF;
    push(c0 + 2, 1, 16'h0AB, "lat1_b");
    push(c0 + 2, 5, 16'h0AB, "lat1_b_nc");
    push(c0 + 2, 3, 16'h000, "lat2_b_pre");
    push(c0 + 3, 3, 16'h0AB, "lat2_b");
    tick;
    enb = 0;
    tick;
    tick;
    @(negedge clk); #1;
    while (sb.size() > 0) begin
      e = sb.pop_front(); t = tq.pop_front(); checks++;
      if (e.due > cyc) begin
        errors++; $display("FAIL %s no output by cycle %0d", t, cyc);
      end else if (hist[e.due][e.sel] !== e.val) begin
        errors++; $display("FAIL %s got %h want %h", t, hist[e.due][e.sel], e.val);
      end
    end
  endtask

  task automatic test_write_modes;
    int c0;
    c0 = cyc;
    enb = 1; web = 1; addrb = 12'd5; dinb = 9'h011;
    ena = 1; wea = 0; addra = 12'h3FF; regcea = 1;
    tick;
    enb = 0; web = 0;
    wea = 1; addra = 12'd5; dina = 9'h122;
    push(c0 + 2, 0, 16'h122, "wmode_write_first");
    push(c0 + 2, 4, 16'h0AB, "wmode_no_change");
    push(c0 + 2, 2, 16'h0AB, "wmode_read_first_pre");
    push(c0 + 3, 2, 16'h011, "wmode_read_first");
    tick;
    wea = 0;
    push(c0 + 3, 0, 16'h122, "wmode_rd_wf");
    push(c0 + 3, 4, 16'h122, "wmode_rd_nc");
    push(c0 + 4, 2, 16'h122, "wmode_rd_rf");
    tick;
    ena = 0;
    tick;
    tick;
    @(negedge clk); #1;
    while (sb.size() > 0) begin
      e = sb.pop_front(); t = tq.pop_front(); checks++;
      if (e.due > cyc) begin
        errors++; $display("FAIL %s no output by cycle %0d", t, cyc);
      end else if (hist[e.due][e.sel] !== e.val) begin
        errors++; $display("FAIL %s got %h want %h", t, hist[e.due][e.sel], e.val);
      end
    end
  endtask

  task automatic test_collision;
    int c0;
    c0 = cyc;
    ena = 1; wea = 1; addra = 12'd9; dina = 9'h055;
    enb = 1; web = 1; addrb = 12'd9; dinb = 9'h1AA;
    push(c0 + 1, 0, 16'h055, "col_ww_a");
    tick;
    web = 0; dina = 9'h0F0;
    push(c0 + 2, 1, 16'h055, "col_rd_old");
    push(c0 + 2, 5, 16'h055, "col_rd_old_2");
    push(c0 + 3, 3, 16'h055, "col_rd_old_reg");
    tick;
    ena = 0; wea = 0;
    push(c0 + 3, 1, 16'h0F0, "col_rd_new");
    push(c0 + 3, 5, 16'h0F0, "col_rd_new_2");
    push(c0 + 4, 3, 16'h0F0, "col_rd_new_reg");
    tick;
    enb = 0;
    tick;
    tick;
    @(negedge clk); #1;
    while (sb.size() > 0) begin
      e = sb.pop_front(); t = tq.pop_front(); checks++;
      if (e.due > cyc) begin
        errors++; $display("FAIL %s no output by cycle %0d", t, cyc);
      end else if (hist[e.due][e.sel] !== e.val) begin
        errors++; $display("FAIL %s got %h want %h", t, hist[e.due][e.sel], e.val);
      end
    end
  endtask

  task automatic test_lanes;
    int c0;
    c0 = cyc;
    wena = 1; wwea = 2'b11; waddra = 12'd7; wdina = 16'hAAAA;
    wenb = 1; wweb = 2'b11; waddrb = 12'd2; wdinb = 16'h2222;
    tick;
    wwea = 2'b01; wdina = 16'h1234;
    wweb = 2'b00; waddrb = 12'd7;
    push(c0 + 2, 6, 16'hAA34, "lane_write_first");
    push(c0 + 2, 7, 16'hAAAA, "lane_cross_old");
    tick;
    waddra = 12'd2; wwea = 2'b01; wdina = 16'h1111;
    waddrb = 12'd2; wweb = 2'b11; wdinb = 16'h3333;
    tick;
    wwea = 2'b00; waddra = 12'd7;
    wweb = 2'b00; waddrb = 12'd2;
    push(c0 + 4, 6, 16'hAA34, "lane_readback");
    push(c0 + 4, 7, 16'h3311, "lane_collision");
    tick;
    wena = 0; wenb = 0;
    tick;
    @(negedge clk); #1;
    while (sb.size() > 0) begin
      e = sb.pop_front(); t = tq.pop_front(); checks++;
      if (e.due > cyc) begin
        errors++; $display("FAIL %s no output by cycle %0d", t, cyc);
      end else if (hist[e.due][e.sel] !== e.val) begin
        errors++; $display("FAIL %s got %h want %h", t, hist[e.due][e.sel], e.val);
      end
    end
  endtask

  task automatic test_oreg_hold;
    int c0;
    c0 = cyc;
    ena = 1; wea = 0; addra = 12'h3FF; regcea = 1;
    tick;
    ena = 0;
    tick;
    regcea = 0; ena = 1; addra = 12'd5;
    push(c0 + 3, 2, 16'h0AB, "oreg_hold_1");
    push(c0 + 4, 2, 16'h0AB, "oreg_hold_2");
    push(c0 + 5, 2, 16'h0AB, "oreg_hold_3");
    push(c0 + 6, 2, 16'h122, "oreg_release");
    tick;
    ena = 0;
    tick;
    tick;
    regcea = 1;
    tick;
    tick;
    @(negedge clk); #1;
    while (sb.size() > 0) begin
      e = sb.pop_front(); t = tq.pop_front(); checks++;
      if (e.due > cyc) begin
        errors++; $display("FAIL %s no output by cycle %0d", t, cyc);
      end else if (hist[e.due][e.sel] !== e.val) begin
        errors++; $display("FAIL %s got %h want %h", t, hist[e.due][e.sel], e.val);
      end
    end
  endtask

  initial begin
    rsta = 1;
    ena = 0; enb = 0; wea = 0; web = 0;
    addra = 0; addrb = 0; dina = 0; dinb = 0;
    regcea = 1; regceb = 1;
    wena = 0; wenb = 0; wwea = 0; wweb = 0;
    waddra = 0; waddrb = 0; wdina = 0; wdinb = 0;
    test_reset;
    test_latency;
    test_write_modes;
    test_collision;
    test_lanes;
    test_oreg_hold;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
